// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op field layout, access sizes,
// FSM state encoding and the alignment rule.
package lsu_pkg;

   localparam int OP_STORE = 3;
   localparam int OP_UNS   = 2;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_ILL  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD     = 3'd1,
      ST_RMW_RD = 3'd2,
      ST_WR     = 3'd3,
      ST_ERR    = 3'd4,
      ST_RESP   = 3'd5
   } lsu_state_t;

   // True when the byte lane cannot start an access of this size (size 3 always fails).
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lane[0];
         SZ_WORD: bad = (lane != 2'd0);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response bus from the execute stage and the word-wide bus to data_memory.
interface lsu_req_if #(parameter int ADR_W = 32);
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_op;
   logic [ADR_W-1:0] req_addr;
   logic [31:0]      req_wdata;
   logic             resp_valid;
   logic [31:0]      resp_rdata;
   logic             resp_err;

   modport master (
      output req_valid, req_op, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );
   modport slave (
      input  req_valid, req_op, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

interface lsu_mem_if #(parameter int ADR_W = 32);
   logic [ADR_W-1:0] read_adr;
   logic [ADR_W-1:0] write_adr;
   logic [31:0]      write_data;
   logic             memread;
   logic             memwrite;
   logic [31:0]      read_data;

   modport master (
      output read_adr, write_adr, write_data, memread, memwrite,
      input  read_data
   );
   modport slave (
      input  read_adr, write_adr, write_data, memread, memwrite,
      output read_data
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends a loaded byte/half, and merges
// store data into the old word for read-modify-write.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] rd_word_i,
   input  logic [1:0]  lane_i,
   input  logic [1:0]  size_i,
   input  logic        uns_i,
   input  logic [31:0] old_word_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] ext_o,
   output logic [31:0] merged_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Load path: pick the addressed lane and extend it to 32 bits.
   always_comb begin
      byte_s = rd_word_i[{lane_i, 3'b000} +: 8];
      half_s = lane_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
      case (size_i)
         SZ_BYTE: ext_o = uns_i ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
         SZ_HALF: ext_o = uns_i ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
         SZ_WORD: ext_o = rd_word_i;
         default: ext_o = 32'h0000_0000;
      endcase
   end

   // Store path: overwrite only the addressed lane(s) of the old word.
   always_comb begin
      merged_o = old_word_i;
      case (size_i)
         SZ_BYTE: merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
         SZ_HALF: begin
            if (lane_i[1]) begin
               merged_o[31:16] = wdata_i[15:0];
            end else begin
               merged_o[15:0] = wdata_i[15:0];
            end
         end
         SZ_WORD: merged_o = wdata_i;
         default: merged_o = old_word_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Requester side of data_memory: one load/store per handshake, sub-word stores
// via read-modify-write, rejects misaligned and out-of-range accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 256,
   parameter int ADR_W     = 32
) (
   input  logic       clk,
   input  logic       reset,
   lsu_req_if.slave   req,
   lsu_mem_if.master  mem
);

   lsu_state_t         state_q, state_d;
   logic [ADR_W-3:0]   word_q;
   logic [1:0]         lane_q;
   logic [1:0]         size_q;
   logic               uns_q;
   logic [31:0]        wdata_q;
   logic [31:0]        old_q;
   logic [31:0]        rdata_q;

   logic               accept_s;
   logic               acc_err_s;
   logic [31:0]        ext_s;
   logic [31:0]        merged_s;

   assign accept_s  = (state_q == ST_IDLE) && req.req_valid;
   assign acc_err_s = misaligned(req.req_op[1:0], req.req_addr[1:0]) ||
                      ({2'b00, req.req_addr[ADR_W-1:2]} >= ADR_W'(MEM_WORDS));

   lsu_lane_align u_align (
      .rd_word_i  (mem.read_data),
      .lane_i     (lane_q),
      .size_i     (size_q),
      .uns_i      (uns_q),
      .old_word_i (old_q),
      .wdata_i    (wdata_q),
      .ext_o      (ext_s),
      .merged_o   (merged_s)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (!req.req_valid) begin
               state_d = ST_IDLE;
            end else if (acc_err_s) begin
               state_d = ST_ERR;
            end else if (!req.req_op[OP_STORE]) begin
               state_d = ST_RD;
            end else if (req.req_op[1:0] == SZ_WORD) begin
               state_d = ST_WR;
            end else begin
               state_d = ST_RMW_RD;
            end
         end
         ST_RD:     state_d = ST_RESP;
         ST_RMW_RD: state_d = ST_WR;
         ST_WR:     state_d = ST_RESP;
         ST_ERR:    state_d = ST_IDLE;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Request capture, load result and old-word capture for read-modify-write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_q  <= '0;
         lane_q  <= 2'd0;
         size_q  <= 2'd0;
         uns_q   <= 1'b0;
         wdata_q <= 32'h0000_0000;
         old_q   <= 32'h0000_0000;
         rdata_q <= 32'h0000_0000;
      end else if (accept_s) begin
         word_q  <= req.req_addr[ADR_W-1:2];
         lane_q  <= req.req_addr[1:0];
         size_q  <= req.req_op[1:0];
         uns_q   <= req.req_op[OP_UNS];
         wdata_q <= req.req_wdata;
         rdata_q <= 32'h0000_0000;
      end else if (state_q == ST_RD) begin
         rdata_q <= ext_s;
      end else if (state_q == ST_RMW_RD) begin
         old_q <= mem.read_data;
      end
   end

   // Outputs decoded from the state register only; idle buses are held at zero.
   always_comb begin
      req.req_ready  = 1'b0;
      req.resp_valid = 1'b0;
      req.resp_rdata = 32'h0000_0000;
      req.resp_err   = 1'b0;
      mem.memread    = 1'b0;
      mem.memwrite   = 1'b0;
      mem.read_adr   = '0;
      mem.write_adr  = '0;
      mem.write_data = 32'h0000_0000;
      case (state_q)
         ST_IDLE: req.req_ready = 1'b1;
         ST_RD, ST_RMW_RD: begin
            mem.memread  = 1'b1;
            mem.read_adr = {2'b00, word_q};
         end
         ST_WR: begin
            mem.memwrite   = 1'b1;
            mem.write_adr  = {2'b00, word_q};
            mem.write_data = merged_s;
         end
         ST_RESP: begin
            req.resp_valid = 1'b1;
            req.resp_rdata = rdata_q;
         end
         ST_ERR: begin
            req.resp_valid = 1'b1;
            req.resp_err   = 1'b1;
         end
         default: req.req_ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural data_memory and a response scoreboard.
`timescale 1ns/1ps
module tb_load_store_unit;
   import lsu_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   lsu_req_if #(.ADR_W(32)) req_bus ();
   lsu_mem_if #(.ADR_W(32)) mem_bus ();

   load_store_unit #(.MEM_WORDS(256), .ADR_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req_bus),
      .mem   (mem_bus)
   );

   // Behavioural data_memory: combinational read, write at posedge.
   logic [31:0] mem_arr [0:255];
   assign mem_bus.read_data = mem_bus.memread ? mem_arr[mem_bus.read_adr[7:0]] : 32'h0;
   always @(posedge clk) begin
      if (mem_bus.memwrite) mem_arr[mem_bus.write_adr[7:0]] <= mem_bus.write_data;
   end

   typedef struct {
      int          id;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          rd;
      int          wr;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          acc_edge = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          resp_cnt = 0;
   int          push_cnt = 0;
   logic [31:0] last_radr = 32'h0;
   logic [31:0] last_wadr = 32'h0;
   logic [31:0] last_wdata = 32'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: strobe bookkeeping, accept timestamps and scoreboard comparison.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         chk("strobe_excl", {31'h0, mem_bus.memread & mem_bus.memwrite}, 32'h0);
         if (mem_bus.memread)  begin rd_cnt++; last_radr = mem_bus.read_adr; end
         if (mem_bus.memwrite) begin wr_cnt++; last_wadr = mem_bus.write_adr; last_wdata = mem_bus.write_data; end
         if (req_bus.req_valid && req_bus.req_ready) begin
            acc_edge = cyc + 1;
            rd_cnt   = 0;
            wr_cnt   = 0;
         end
         if (req_bus.resp_valid) begin
            resp_cnt++;
            chk("resp_expected", {31'h0, sb_q.size() != 0}, 32'h1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               chk($sformatf("rdata#%0d", e.id), req_bus.resp_rdata, e.rdata);
               chk($sformatf("err#%0d", e.id), {31'h0, req_bus.resp_err}, {31'h0, e.err});
               chk($sformatf("latency#%0d", e.id), 32'(cyc - acc_edge + 1), 32'(e.lat));
               chk($sformatf("memread_cnt#%0d", e.id), 32'(rd_cnt), 32'(e.rd));
               chk($sformatf("memwrite_cnt#%0d", e.id), 32'(wr_cnt), 32'(e.wr));
            end
         end
      end
   end

   task automatic issue(input int id, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                        input int lat, input int rd, input int wr, input bit keep, input bit want_resp);
      exp_t e;
      bit   accepted = 1'b0;
      if (want_resp) begin
         e.id = id; e.rdata = exp_rdata; e.err = exp_err; e.lat = lat; e.rd = rd; e.wr = wr;
         sb_q.push_back(e);
         push_cnt++;
      end
      req_bus.req_valid = 1'b1;
      req_bus.req_op    = op;
      req_bus.req_addr  = addr;
      req_bus.req_wdata = wdata;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (req_bus.req_ready) begin
            accepted = 1'b1;
            break;
         end
      end
      chk($sformatf("accept#%0d", id), {31'h0, accepted}, 32'h1);
      @(posedge clk);
      #2;
      if (!keep) req_bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         if (sb_q.size() == 0) break;
         @(posedge clk);
         #2;
      end
      chk("drain", 32'(sb_q.size()), 32'h0);
   endtask

   initial begin
      req_bus.req_valid = 1'b0;
      req_bus.req_op    = 4'h0;
      req_bus.req_addr  = 32'h0;
      req_bus.req_wdata = 32'h0;
      for (int i = 0; i < 256; i++) mem_arr[i] = 32'(i);
      mem_arr[3] = 32'h80FF7F01;

      #1;
      chk("rst_req_ready", {31'h0, req_bus.req_ready}, 32'h1);
      chk("rst_resp_valid", {31'h0, req_bus.resp_valid}, 32'h0);
      chk("rst_resp_rdata", req_bus.resp_rdata, 32'h0);
      chk("rst_resp_err", {31'h0, req_bus.resp_err}, 32'h0);
      chk("rst_strobes", {30'h0, mem_bus.memread, mem_bus.memwrite}, 32'h0);
      chk("rst_read_adr", mem_bus.read_adr, 32'h0);
      chk("rst_write_adr", mem_bus.write_adr, 32'h0);
      chk("rst_write_data", mem_bus.write_data, 32'h0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;

      // Loads from word 3 = 0x80FF7F01
      issue(1, 4'b0010, 32'h0C, 32'h0, 32'h80FF7F01, 1'b0, 2, 1, 0, 0, 1); drain();
      chk("lw_read_adr", last_radr, 32'd3);
      issue(2, 4'b0000, 32'h0F, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1, 0, 0, 1); drain();
      issue(3, 4'b0100, 32'h0F, 32'h0, 32'h00000080, 1'b0, 2, 1, 0, 0, 1); drain();
      issue(4, 4'b0001, 32'h0E, 32'h0, 32'hFFFF80FF, 1'b0, 2, 1, 0, 0, 1); drain();
      issue(5, 4'b0101, 32'h0C, 32'h0, 32'h00007F01, 1'b0, 2, 1, 0, 0, 1); drain();
      issue(6, 4'b0000, 32'h0D, 32'h0, 32'h0000007F, 1'b0, 2, 1, 0, 0, 1); drain();

      // Sub-word store by read-modify-write
      issue(7, 4'b1000, 32'h0D, 32'h12345678, 32'h0, 1'b0, 3, 1, 1, 0, 1); drain();
      chk("sb_write_data", last_wdata, 32'h80FF7801);
      chk("sb_write_adr", last_wadr, 32'd3);
      issue(8, 4'b0010, 32'h0C, 32'h0, 32'h80FF7801, 1'b0, 2, 1, 0, 0, 1); drain();

      // Last word in range, then error cases
      issue(9, 4'b1010, 32'h3FC, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 0, 1); drain();
      chk("sw_write_adr", last_wadr, 32'd255);
      chk("sw_mem255", mem_arr[255], 32'hDEADBEEF);
      issue(10, 4'b0010, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0, 1); drain();
      issue(11, 4'b0001, 32'h05, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0, 1); drain();
      issue(12, 4'b0010, 32'h06, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0, 1); drain();
      issue(13, 4'b0011, 32'h00, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0, 1); drain();

      // Back-to-back with req_valid held high
      issue(14, 4'b0000, 32'h0F, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1, 0, 1, 1);
      issue(15, 4'b0101, 32'h0C, 32'h0, 32'h00007801, 1'b0, 2, 1, 0, 1, 1);
      issue(16, 4'b1010, 32'h10, 32'hA5A5A5A5, 32'h0, 1'b0, 2, 0, 1, 1, 1);
      issue(17, 4'b0010, 32'h10, 32'h0, 32'hA5A5A5A5, 1'b0, 2, 1, 0, 0, 1);
      drain();

      // Reset during the WR cycle of SB 0x20
      issue(18, 4'b1000, 32'h20, 32'hFFFFFFAA, 32'h0, 1'b0, 3, 1, 1, 0, 0);
      @(posedge clk);
      #2;
      chk("wr_cycle_memwrite", {31'h0, mem_bus.memwrite}, 32'h1);
      reset = 1'b0;
      #1;
      chk("rst_memwrite_drop", {30'h0, mem_bus.memwrite, mem_bus.memread}, 32'h0);
      chk("rst_no_resp", {31'h0, req_bus.resp_valid}, 32'h0);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("post_rst_ready", {31'h0, req_bus.req_ready}, 32'h1);
      chk("word8_intact", mem_arr[8], 32'd8);
      @(posedge clk);
      #2;
      issue(19, 4'b0010, 32'h20, 32'h0, 32'h00000008, 1'b0, 2, 1, 0, 0, 1); drain();

      repeat (3) @(posedge clk);
      #2;
      chk("resp_count", 32'(resp_cnt), 32'(push_cnt));
      chk("sb_empty", 32'(sb_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
